// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the ASCON sequencing controller.
// ASCON_HASH_EN enables the hash mode (mode 2) and its squeeze phase.
package ascon_cfg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KEY_INIT,
    ST_AD_WAIT,
    ST_AD_PERM,
    ST_DOM_SEP,
    ST_TXT_WAIT,
    ST_TXT_PERM,
    ST_KEY_FIN,
    ST_FINAL,
    ST_TAG,
    ST_SQZ_PERM,
    ST_SQZ_OUT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_HASH = 2'd2,
    MODE_RSVD = 2'd3
  } ascon_mode_e;

  localparam int HASH_OUT_BLOCKS = 4;
  localparam int MAX_ROUNDS      = 12;

  // Modes that launch an operation; anything else leaves the controller idle.
  function automatic logic mode_supported(input logic [1:0] m);
`ifdef ASCON_HASH_EN
    return (m == MODE_ENC) || (m == MODE_DEC) || (m == MODE_HASH);
`else
    return (m == MODE_ENC) || (m == MODE_DEC);
`endif
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_cnt.sv
// Loadable 4-bit round down-counter; holds at zero and reports the
// round-constant index as MAX_ROUNDS-1-cnt.
module round_cnt
  import ascon_cfg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic [3:0] val_i,
  input  logic       en_i,
  output logic       zero_o,
  output logic [3:0] idx_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);
  assign idx_o  = 4'(MAX_ROUNDS - 1) - cnt_q;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON sequencing controller: phase FSM, round counter and Moore output decode.
// Optional hash/squeeze support is compiled in with ASCON_HASH_EN.
module ascon_ctrl_fsm
  import ascon_cfg::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic        no_ad_i,
  input  logic        ad_valid_i,
  output logic        ad_ready_o,
  input  logic        txt_valid_i,
  output logic        txt_ready_o,
  input  logic        last_ad_flag_i,
  input  logic        invalid_flag_i,
  output logic        perm_en_o,
  output logic [3:0]  round_idx_o,
  output logic        xor_key_o,
  output logic        dom_sep_o,
  output logic        last_ad_flag_clr_o,
  output logic        last_cc_o,
  output logic        out_valid_o,
  output logic        busy_o,
  output ctrl_state_e dbg_state_o
);

  // Handshake: a block transfers on the rising edge where valid and ready are
  // both high; ready is decoded from state alone and valid may wait on ready.

  ctrl_state_e state_q, state_d;
  logic        no_ad_q, no_ad_d;
  logic        chk_q, chk_d;
  logic        is_hash;
  logic        sqz_last;

  logic        cnt_load;
  logic [3:0]  cnt_val;
  logic        cnt_zero;
  logic [3:0]  cnt_idx;

`ifdef ASCON_HASH_EN
  logic       hash_q, hash_d;
  logic [1:0] sqz_q, sqz_d;
  assign is_hash  = hash_q;
  assign sqz_last = (state_q == ST_SQZ_OUT) && (sqz_q == 2'(HASH_OUT_BLOCKS - 1));
`else
  assign is_hash  = 1'b0;
  assign sqz_last = 1'b0;
`endif

  round_cnt u_round_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (cnt_load),
    .val_i   (cnt_val),
    .en_i    (perm_en_o),
    .zero_o  (cnt_zero),
    .idx_o   (cnt_idx)
  );

  always_comb begin
    state_d  = state_q;
    no_ad_d  = no_ad_q;
    chk_d    = chk_q;
    cnt_load = 1'b0;
    cnt_val  = 4'(ROUNDS_A - 1);
`ifdef ASCON_HASH_EN
    hash_d   = hash_q;
    sqz_d    = sqz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && mode_supported(mode_i)) begin
          state_d  = ST_INIT;
          no_ad_d  = no_ad_i;
          cnt_load = 1'b1;
`ifdef ASCON_HASH_EN
          hash_d   = (mode_i == MODE_HASH);
          sqz_d    = 2'd0;
`endif
        end
      end
      ST_INIT: begin
        if (cnt_zero) state_d = is_hash ? ST_TXT_WAIT : ST_KEY_INIT;
      end
      ST_KEY_INIT: state_d = no_ad_q ? ST_DOM_SEP : ST_AD_WAIT;
      ST_AD_WAIT: begin
        if (ad_valid_i) begin
          state_d  = ST_AD_PERM;
          cnt_load = 1'b1;
          cnt_val  = 4'(ROUNDS_B - 1);
        end
      end
      ST_AD_PERM: begin
        if (cnt_zero) state_d = last_ad_flag_i ? ST_DOM_SEP : ST_AD_WAIT;
      end
      ST_DOM_SEP: state_d = ST_TXT_WAIT;
      ST_TXT_WAIT: begin
        if (txt_valid_i) begin
          state_d  = ST_TXT_PERM;
          cnt_load = 1'b1;
          cnt_val  = is_hash ? 4'(ROUNDS_A - 1) : 4'(ROUNDS_B - 1);
          chk_d    = !is_hash;
        end
      end
      ST_TXT_PERM: begin
        // The AEAD check cycle sees the flag set by the block just accepted.
        if (chk_q) begin
          chk_d = 1'b0;
          if (invalid_flag_i) state_d = ST_KEY_FIN;
        end else if (cnt_zero) begin
          if (invalid_flag_i) state_d = is_hash ? ST_SQZ_OUT : ST_KEY_FIN;
          else                state_d = ST_TXT_WAIT;
        end
      end
      ST_KEY_FIN: begin
        state_d  = ST_FINAL;
        cnt_load = 1'b1;
      end
      ST_FINAL: begin
        if (cnt_zero) state_d = ST_TAG;
      end
      ST_TAG: state_d = ST_IDLE;
`ifdef ASCON_HASH_EN
      ST_SQZ_OUT: begin
        sqz_d = sqz_q + 2'd1;
        if (sqz_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_SQZ_PERM;
          cnt_load = 1'b1;
        end
      end
      ST_SQZ_PERM: begin
        if (cnt_zero) state_d = ST_SQZ_OUT;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      no_ad_q <= 1'b0;
      chk_q   <= 1'b0;
`ifdef ASCON_HASH_EN
      hash_q  <= 1'b0;
      sqz_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      no_ad_q <= no_ad_d;
      chk_q   <= chk_d;
`ifdef ASCON_HASH_EN
      hash_q  <= hash_d;
      sqz_q   <= sqz_d;
`endif
    end
  end

  assign perm_en_o = (state_q == ST_INIT) || (state_q == ST_AD_PERM) ||
                     (state_q == ST_FINAL) || (state_q == ST_SQZ_PERM) ||
                     ((state_q == ST_TXT_PERM) && !chk_q);
  assign round_idx_o = perm_en_o ? cnt_idx : 4'd0;
  assign xor_key_o   = (state_q == ST_KEY_INIT) || (state_q == ST_KEY_FIN) ||
                       (state_q == ST_TAG);
  assign dom_sep_o   = (state_q == ST_DOM_SEP);
  // Hash never passes DOM_SEP, so the AD flag is cleared on leaving INIT instead.
  assign last_ad_flag_clr_o = (state_q == ST_DOM_SEP) ||
                              ((state_q == ST_INIT) && cnt_zero && is_hash) ||
                              sqz_last;
  assign last_cc_o   = ((state_q == ST_FINAL) && cnt_zero) || sqz_last;
  assign out_valid_o = (state_q == ST_TAG) || (state_q == ST_SQZ_OUT);
  assign busy_o      = (state_q != ST_IDLE);
  assign ad_ready_o  = (state_q == ST_AD_WAIT);
  assign txt_ready_o = (state_q == ST_TXT_WAIT);
  assign dbg_state_o = state_q;

endmodule

// File: doc/ascon_ctrl_fsm.md
# ascon_ctrl_fsm

Sequencing controller for the ASCON core. It drives the permutation round counter and the per-phase datapath selects through initialization, associated-data absorption, domain separation, text processing, finalization and tag/digest output. It hands block handshakes to the input buffers and drives `last_ad_flag_clr_o` and `last_cc_o` into the flag block. It also consumes the flag block's `last_ad_flag_o` and `invalid_flag_o`.

## Interface
Reset is asynchronous and active-low: `rst_n_i`. There is one clock: `clk_i`.

Parameters:
- `ROUNDS_A`, default 12: rounds for the initialization, finalization and hash permutations.
- `ROUNDS_B`, default 6: rounds for the AD and text permutations (AEAD).

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `start_i` in 1: one-cycle operation start. Sampled only in IDLE.
- `mode_i` in 2: 0 = encrypt, 1 = decrypt, 2 = hash, 3 = reserved. Sampled with `start_i`.
- `no_ad_i` in 1: operation has no AD. Sampled with `start_i`.
- `ad_valid_i` in 1 / `ad_ready_o` out 1: AD block handshake.
- `txt_valid_i` in 1 / `txt_ready_o` out 1: text/message block handshake.
- `last_ad_flag_i` in 1: from the flag block. Set by the last accepted AD block.
- `invalid_flag_i` in 1: from the flag block. Set by the last accepted text block.
- `perm_en_o` out 1: permutation round is active this cycle.
- `round_idx_o` out 4: current round constant index, 12-ROUNDS .. 11.
- `xor_key_o` out 1: XOR the key into the state this cycle.
- `dom_sep_o` out 1: XOR the domain-separation bit this cycle.
- `last_ad_flag_clr_o` out 1: clear pulse to the flag block.
- `last_cc_o` out 1: last permutation cycle of the operation. Clears the invalid flag.
- `out_valid_o` out 1: tag or digest block valid on the datapath.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
States are IDLE, INIT, KEY_INIT, AD_WAIT, AD_PERM, DOM_SEP, TXT_WAIT, TXT_PERM, KEY_FIN, FINAL, TAG, SQZ_PERM, SQZ_OUT.

- IDLE: `start_i` with mode 0/1/2 → INIT. Mode 3 is ignored and the FSM stays in IDLE. A start while busy is ignored.
- INIT: lasts ROUNDS_A cycles with `perm_en_o`=1. On the final round, AEAD goes to KEY_INIT; hash goes to TXT_WAIT.
- KEY_INIT: 1 cycle with `xor_key_o`=1. Goes to DOM_SEP if `no_ad_i`, otherwise to AD_WAIT.
- AD_WAIT: `ad_ready_o`=1. On handshake → AD_PERM.
- AD_PERM: ROUNDS_B rounds. On the final round, goes to DOM_SEP if `last_ad_flag_i`, otherwise to AD_WAIT.
- DOM_SEP: 1 cycle with `dom_sep_o`=1 and `last_ad_flag_clr_o`=1. Goes to TXT_WAIT.
- TXT_WAIT: `txt_ready_o`=1. On handshake:
  - AEAD: → TXT_PERM, or → KEY_FIN when this block sets `invalid_flag_i`. `invalid_flag_i` is sampled the cycle after the handshake, so KEY_FIN is entered via a 1-cycle TXT_PERM check with no rounds.
  - Hash: → TXT_PERM with ROUNDS_A rounds.
- TXT_PERM: ROUNDS_B rounds (AEAD) or ROUNDS_A rounds (hash). On completion:
  - `invalid_flag_i`=1 in AEAD → KEY_FIN.
  - `invalid_flag_i`=1 in hash → SQZ_OUT.
  - Otherwise → TXT_WAIT.
- KEY_FIN: 1 cycle with `xor_key_o`=1, then FINAL.
- FINAL: ROUNDS_A rounds, with `last_cc_o`=1 on the last round. Then TAG.
- TAG: 1 cycle with `xor_key_o`=1 and `out_valid_o`=1, then IDLE.
- Hash squeeze:
  - SQZ_OUT: `out_valid_o`=1 for 1 cycle. The 2-bit squeeze counter increments.
  - After the 4th block (counter wraps from 3 to 0) → IDLE, with `last_cc_o` pulsed in that SQZ_OUT cycle and the flags cleared.
  - Otherwise → SQZ_PERM for ROUNDS_A rounds, then SQZ_OUT.
- Round counter: 4-bit down-counter loaded with ROUNDS-1 on phase entry. `round_idx_o` = 12 − ROUNDS + (ROUNDS − 1 − cnt). The phase ends when cnt = 0, with no wrap.
- `last_ad_flag_clr_o` is also pulsed when leaving INIT in hash mode, so a stale AD flag never leaks between operations.

## Timing
- Reset value of every output is 0. The state resets to IDLE, and the counters reset to 0.
- Reset asserted mid-operation: the FSM returns to IDLE immediately. No tag and no pulses are emitted.
- All outputs are Moore, decoded from state and counter registers. There are no combinational input→output paths except the `*_ready_o` gating, which also depends only on state.
- Encrypt, `no_ad_i`=1, one text block accepted at the first TXT_WAIT cycle:
  - START + ROUNDS_A + 1 (KEY_INIT) + 1 (DOM_SEP) + 1 (TXT_WAIT) + 1 (check) + 1 (KEY_FIN) + ROUNDS_A + 1 (TAG) = 30 cycles from the `start_i` cycle to `out_valid_o`.
- Ready remains asserted, and the FSM waits indefinitely, while valid is low.

## Configuration
`ASCON_HASH_EN`:
- Defined: mode 2 is supported, along with the SQZ_OUT/SQZ_PERM states and the squeeze counter.
- Undefined: mode 2 is treated as reserved (ignored in IDLE), and the squeeze states and counter are not synthesized.

## Structure
- Package `ascon_cfg` holds:
  - the state enum `ctrl_state_e`;
  - the mode enum `ascon_mode_e`;
  - the constants `HASH_OUT_BLOCKS` = 4 and `MAX_ROUNDS` = 12.
- One sub-module, `round_cnt`: loadable down-counter with `load_i`, `val_i`, `en_i`, `zero_o` and `idx_o`.

## Test plan
- Encrypt, `no_ad_i`=1, one text block → `out_valid_o` exactly 30 cycles after `start_i`; exactly one `dom_sep_o` pulse and one `last_ad_flag_clr_o` pulse; `last_cc_o` 1 cycle before TAG.
- Encrypt with 2 AD blocks and 2 text blocks → `perm_en_o` high for 12+6+6+6+12 = 42 cycles total; `ad_ready_o` high only in AD_WAIT.
- `start_i` with mode 3, and `start_i` while busy → no state change; `busy_o` stays 0 (mode 3 case) or keeps the operation unaffected (busy case).
- Hash with one message block (`ASCON_HASH_EN`) → 4 `out_valid_o` pulses, each separated by 12 `perm_en_o` cycles; then IDLE.
- `rst_n_i` asserted during FINAL round 5 → all outputs 0 in the same cycle; a fresh start completes normally.
- `ad_valid_i` held low for 10 cycles in AD_WAIT → FSM holds with `ad_ready_o`=1; after valid goes high, the sequence continues with unchanged latency.
